// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one external combinational ALU between two requesters.
// Accept -> EXEC (ALU settles on the registered operands) -> RESP (registered result held until consumed).
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [OPW-1:0]   req_op_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_result_0,
  output logic             rsp_zero_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [OPW-1:0]   req_op_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result_1,
  output logic             rsp_zero_1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [OPW-1:0]   op_q;
  logic             zero_q;

  logic             win_c;
  logic             accept_c;
  logic             rsp_done_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)   state_d = EXEC;
      EXEC:                    state_d = RESP;
      RESP:    if (rsp_done_c) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Arbitration and handshake decode; a lone requester wins, a tie goes to rr_ptr
  always_comb begin
    win_c       = 1'b0;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    accept_c    = 1'b0;
    rsp_done_c  = 1'b0;
    win_c       = (req_valid_0 && req_valid_1) ? rr_ptr_q : req_valid_1;
    if (state_q == IDLE) begin
      req_ready_0 = req_valid_0 && !win_c;
      req_ready_1 = req_valid_1 && win_c;
      accept_c    = req_valid_0 || req_valid_1;
    end
    if (state_q == RESP) rsp_done_c = owner_q ? rsp_ready_1 : rsp_ready_0;
  end

  // Operand capture, result capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        owner_q <= win_c;
        a_q     <= win_c ? req_a_1  : req_a_0;
        b_q     <= win_c ? req_b_1  : req_b_0;
        op_q    <= win_c ? req_op_1 : req_op_0;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
      if (rsp_done_c) rr_ptr_q <= ~owner_q;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign rsp_valid_0  = (state_q == RESP) && !owner_q;
  assign rsp_valid_1  = (state_q == RESP) && owner_q;
  assign rsp_result_0 = res_q;
  assign rsp_result_1 = res_q;
  assign rsp_zero_0   = zero_q;
  assign rsp_zero_1   = zero_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;

endmodule
